// File: rtl/mac_seq.sv
// mac_seq: sequencer that runs one dot-product job on an external MAC.
// A job (base_addr, len) is accepted in IDLE, the accumulator is cleared,
// len operand reads are issued at consecutive addresses, each read is
// followed RD_LAT cycles later by a MAC accumulate enable, and after the
// pipeline drains the accumulator value is returned on the res_* handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start/start_ready     job request / accepted when both high (IDLE only)
//   base_addr, len        first operand address, element count (0..2^ADDR_W)
//   abort                 synchronous job cancel; busy = job in progress
//   rd_en, rd_addr        operand read strobe/address (shared A/B buffers)
//   mac_en, mac_clr       MAC accumulate enable / accumulator clear
//   mac_out, mac_ovr      MAC accumulator value / overflow flag
//   res_valid/res_ready   result handshake; res_data result, res_ovr overflow
//
// Build option: define MAC_SEQ_OVR_TRACK_EN to report MAC overflow on res_ovr;
// otherwise res_ovr is tied low and mac_ovr is ignored.
module mac_seq #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                start_ready,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     len,
  input  logic                abort,
  output logic                busy,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                mac_en,
  output logic                mac_clr,
  input  logic signed [N-1:0] mac_out,
  input  logic                mac_ovr,
  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [N-1:0] res_data,
  output logic                res_ovr
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [2:0]          dcnt_q, dcnt_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                mac_clr_q, mac_clr_d;
  logic [RD_LAT-1:0]   dly_q, dly_d;
  logic signed [N-1:0] res_data_q, res_data_d;
  logic                res_ovr_q, res_ovr_d;
  logic                ovr_now;

`ifdef MAC_SEQ_OVR_TRACK_EN
  logic ovr_sticky_q, ovr_sticky_d;
  logic mac_en_d1_q, mac_en_d1_d;
  logic ovr_hit;

  // Overflow counts if seen in a mac_en cycle or the cycle right after it.
  assign ovr_hit = mac_ovr & (mac_en | mac_en_d1_q);
  assign ovr_now = ovr_sticky_q | ovr_hit;
`else
  logic unused_mac_ovr;
  assign unused_mac_ovr = mac_ovr;
  assign ovr_now        = 1'b0;
`endif

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign mac_clr     = mac_clr_q;
  assign mac_en      = dly_q[RD_LAT-1];
  assign res_data    = res_data_q;
  assign res_ovr     = res_ovr_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    dcnt_d     = dcnt_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    mac_clr_d  = 1'b0;
    res_data_d = res_data_q;
    res_ovr_d  = res_ovr_q;

    dly_d[0] = rd_en_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end

`ifdef MAC_SEQ_OVR_TRACK_EN
    mac_en_d1_d  = mac_en;
    ovr_sticky_d = ovr_sticky_q | ovr_hit;
    if (state_q == CLEAR) ovr_sticky_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          len_d     = len;
          mac_clr_d = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        dcnt_d = '0;
        if (len_q != '0) begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q;
          cnt_d     = (ADDR_W+1)'(1);
          state_d   = ISSUE;
        end else begin
          state_d = DRAIN;
        end
      end
      ISSUE: begin
        // cnt_q holds the number of reads already issued.
        if (cnt_q == len_q) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          res_data_d = mac_out;
          res_ovr_d  = ovr_now;
          state_d    = DONE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_ovr_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition, including the DONE handshake.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      rd_en_d   = 1'b0;
      mac_clr_d = 1'b0;
      dly_d     = '0;
      res_ovr_d = 1'b0;
`ifdef MAC_SEQ_OVR_TRACK_EN
      mac_en_d1_d  = 1'b0;
      ovr_sticky_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      mac_clr_q  <= 1'b0;
      dly_q      <= '0;
      res_data_q <= '0;
      res_ovr_q  <= 1'b0;
`ifdef MAC_SEQ_OVR_TRACK_EN
      mac_en_d1_q  <= 1'b0;
      ovr_sticky_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      mac_clr_q  <= mac_clr_d;
      dly_q      <= dly_d;
      res_data_q <= res_data_d;
      res_ovr_q  <= res_ovr_d;
`ifdef MAC_SEQ_OVR_TRACK_EN
      mac_en_d1_q  <= mac_en_d1_d;
      ovr_sticky_q <= ovr_sticky_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed, table-driven bench for mac_seq (RD_LAT=1).
// The environment models operand buffers A[a]=a, B[a]=3 with a one-cycle
// read pipe and an accumulator driven by mac_clr/mac_en, so each result is
// 3 * (sum of addresses read). Expected values below are hand-computed.
module tb_mac_seq;
  localparam int N = 32;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;
`ifdef MAC_SEQ_OVR_TRACK_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start, start_ready, abort, busy;
  logic [ADDR_W-1:0] base_addr, rd_addr;
  logic [ADDR_W:0] len;
  logic rd_en, mac_en, mac_clr, mac_ovr, res_valid, res_ready, res_ovr;
  logic signed [N-1:0] mac_out, res_data;

  always #5 clk = ~clk;

  mac_seq #(.N(N), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .base_addr(base_addr), .len(len), .abort(abort), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_out(mac_out), .mac_ovr(mac_ovr), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ovr(res_ovr)
  );

  // Environment: operand buffers, read pipe, accumulator.
  logic signed [N-1:0] mem_a [256];
  logic signed [N-1:0] mem_b [256];
  logic signed [N-1:0] pa [RD_LAT];
  logic signed [N-1:0] pb [RD_LAT];
  logic signed [N-1:0] acc = '0;
  logic ovr_arm = 1'b0;

  assign mac_out = acc;
  assign mac_ovr = ovr_arm & mac_en;

  always @(posedge clk) begin
    pa[0] <= mem_a[rd_addr];
    pb[0] <= mem_b[rd_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + pa[RD_LAT-1] * pb[RD_LAT-1];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Issues one job and follows it until res_valid (bounded). Returns at the
  // negedge of the first res_valid cycle; k counts cycles after acceptance.
  task automatic run_job(input logic [7:0] b, input logic [8:0] l,
                         output int lat, output int nrd, output int nmac, output int nclr);
    logic [7:0] ea;
    lat = -1; nrd = 0; nmac = 0; nclr = 0;
    @(negedge clk);
    base_addr = b; len = l; start = 1'b1;
    chk("start_ready_idle", 32'(start_ready), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (rd_en) begin
        ea = b + nrd[7:0];
        chk("rd_addr", 32'(rd_addr), 32'(ea));
        nrd++;
      end
      if (mac_en) nmac++;
      if (mac_clr) nclr++;
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk("job_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];
  int lat, nrd, nmac, nclr, cnt_mac, cnt_rd, cnt_val;
  logic [31:0] held;

  initial begin
    vecs[0] = '{8'h10, 9'd4, 32'd210,  8};   // 3*(16+17+18+19)
    vecs[1] = '{8'hFE, 9'd3, 32'd1527, 7};   // 3*(254+255+0)
    vecs[2] = '{8'h00, 9'd0, 32'd0,    4};
    vecs[3] = '{8'h05, 9'd1, 32'd15,   5};
    vecs[4] = '{8'h80, 9'd5, 32'd1950, 9};   // 3*(128..132)

    for (int a = 0; a < 256; a++) begin
      mem_a[a] = a;
      mem_b[a] = 3;
    end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    base_addr = '0; len = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_mac_en", 32'(mac_en), 32'd0);
    chk("rst_mac_clr", 32'(mac_clr), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_ovr", 32'(res_ovr), 32'd0);
    rst_n = 1'b1;

    // Table-driven jobs with res_ready held high.
    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].base, vecs[v].len, lat, nrd, nmac, nclr);
      chk("latency", 32'(lat), 32'(vecs[v].exp_lat));
      chk("rd_count", 32'(nrd), 32'(vecs[v].len));
      chk("mac_en_count", 32'(nmac), 32'(vecs[v].len));
      chk("mac_clr_count", 32'(nclr), 32'd1);
      chk("res_data", res_data, vecs[v].exp_data);
      chk("res_ovr_clean", 32'(res_ovr), 32'd0);
      @(negedge clk);
      chk("back_to_idle", 32'(busy), 32'd0);
      chk("res_valid_drop", 32'(res_valid), 32'd0);
    end

    // Abort two cycles into ISSUE of a len=8 job.
    @(negedge clk);
    base_addr = 8'h40; len = 9'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);          // cycles 1 (CLEAR), 2, 3 (ISSUE)
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    cnt_mac = 0; cnt_rd = 0; cnt_val = 0;
    for (int k = 0; k < 15; k++) begin
      if (mac_en) cnt_mac++;
      if (rd_en) cnt_rd++;
      if (res_valid) cnt_val++;
      @(negedge clk);
    end
    chk("abort_no_mac_en", 32'(cnt_mac), 32'd0);
    chk("abort_no_rd_en", 32'(cnt_rd), 32'd0);
    chk("abort_no_res_valid", 32'(cnt_val), 32'd0);
    run_job(8'h20, 9'd2, lat, nrd, nmac, nclr);
    chk("post_abort_lat", 32'(lat), 32'd6);
    chk("post_abort_data", res_data, 32'd195);   // 3*(32+33)
    chk("post_abort_mac_en", 32'(nmac), 32'd2);

    // Abort together with start in IDLE: job must still be accepted.
    @(negedge clk);
    base_addr = 8'h00; len = 9'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    @(negedge clk);
    chk("idle_abort_ignored", 32'(busy), 32'd1);
    chk("idle_abort_clr", 32'(mac_clr), 32'd1);
    repeat (3) @(negedge clk);
    chk("idle_abort_valid", 32'(res_valid), 32'd1);

    // Back-pressure: res_ready low for 5 cycles in DONE, start ignored.
    @(negedge clk);
    res_ready = 1'b0;
    run_job(8'h10, 9'd4, lat, nrd, nmac, nclr);
    chk("stall_lat", 32'(lat), 32'd8);
    held = res_data;
    chk("stall_data", held, 32'd210);
    base_addr = 8'h33; len = 9'd2; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_data_stable", res_data, 32'd210);
      chk("stall_start_ready", 32'(start_ready), 32'd0);
    end
    res_ready = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("stall_release", 32'(res_valid), 32'd0);
    chk("stall_start_ignored", 32'(busy), 32'd0);

    // Overflow tracking, then a clean job.
    ovr_arm = 1'b1;
    run_job(8'h10, 9'd4, lat, nrd, nmac, nclr);
    ovr_arm = 1'b0;
    chk("ovr_job_res_ovr", 32'(res_ovr), 32'(EXP_OVR));
    run_job(8'h05, 9'd1, lat, nrd, nmac, nclr);
    chk("clean_job_res_ovr", 32'(res_ovr), 32'd0);

    // Reset mid-job, then a normal job.
    @(negedge clk);
    base_addr = 8'h50; len = 9'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_en", 32'(rd_en), 32'd0);
    chk("midrst_mac_en", 32'(mac_en), 32'd0);
    chk("midrst_res_data", res_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_val = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) cnt_val++;
    end
    chk("midrst_no_valid", 32'(cnt_val), 32'd0);
    run_job(8'h10, 9'd4, lat, nrd, nmac, nclr);
    chk("after_rst_lat", 32'(lat), 32'd8);
    chk("after_rst_data", res_data, 32'd210);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
